// File: rtl/cache_tag_array_if.sv
// Request/result bundle between the cache controller (master) and the tag array (slave).
interface cache_tag_array_if #(
    parameter int unsigned TAG_LEN   = 13,
    parameter int unsigned INDEX_LEN = 10,
    parameter int unsigned WAYS      = 2,
    parameter int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
);
    logic                 ready;
    logic                 re;
    logic                 we;
    logic [INDEX_LEN-1:0] addr;
    logic [TAG_LEN-1:0]   tag_in;
    logic [WAY_W-1:0]     way_in;
    logic [2:0]           status_in;
    logic                 rvalid;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [2:0]           hit_status;
    logic [WAY_W-1:0]     victim_way;
    logic [TAG_LEN-1:0]   victim_tag;
    logic [2:0]           victim_status;

    modport master (
        input  ready, rvalid, hit, hit_way, hit_status, victim_way, victim_tag, victim_status,
        output re, we, addr, tag_in, way_in, status_in
    );

    modport slave (
        output ready, rvalid, hit, hit_way, hit_status, victim_way, victim_tag, victim_status,
        input  re, we, addr, tag_in, way_in, status_in
    );
endinterface

// File: rtl/cache_tag_array.sv
// N-way set-associative tag/status store with per-set tree pseudo-LRU victim selection
// and a sequential clearing sweep after reset.
module cache_tag_array #(
    parameter int unsigned TAG_LEN   = 13,
    parameter int unsigned INDEX_LEN = 10,
    parameter int unsigned WAYS      = 2
) (
    input logic              clk,
    input logic              reset,
    cache_tag_array_if.slave bus
);
    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned SETS    = 2 ** INDEX_LEN;
    localparam int unsigned ENTRY_W = TAG_LEN + 3;

    typedef enum logic {StInit, StIdle} state_e;

    state_e               state_q;
    logic [INDEX_LEN-1:0] sweep_q;
    logic                 ready_q;
    logic                 rvalid_q;
    logic                 hit_q;
    logic [WAY_W-1:0]     hit_way_q;
    logic [2:0]           hit_status_q;
    logic [WAY_W-1:0]     victim_way_q;
    logic [TAG_LEN-1:0]   victim_tag_q;
    logic [2:0]           victim_status_q;

    logic [2:0] plru_q [SETS];

    logic                 init_wr;
    logic                 do_write;
    logic                 do_lookup;
    logic [INDEX_LEN-1:0] wr_idx;
    logic [ENTRY_W-1:0]   wr_data;
    logic [ENTRY_W-1:0]   rd_entry [WAYS];

    assign init_wr   = reset && (state_q == StInit);
    assign do_write  = reset && (state_q == StIdle) && bus.we;
    assign do_lookup = reset && (state_q == StIdle) && bus.re && !bus.we;
    assign wr_idx    = init_wr ? sweep_q : bus.addr;
    assign wr_data   = init_wr ? '0 : {bus.status_in, bus.tag_in};

    // One RAM per way, entry layout {status, tag}; valid is status bit 0.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [ENTRY_W-1:0] ram_q [SETS];
        logic               wr_en;

        assign wr_en = init_wr || (do_write && (bus.way_in == WAY_W'(w)));

        always_ff @(posedge clk) begin
            if (wr_en) begin
                ram_q[wr_idx] <= wr_data;
            end
        end

        assign rd_entry[w] = ram_q[bus.addr];
    end

    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] nb;
        nb = bits;
        if (WAYS == 2) begin
            nb[0] = ~way[0];
        end else if (WAYS == 4) begin
            nb[0] = ~way[1];
            if (way[1]) begin
                nb[2] = ~way[0];
            end else begin
                nb[1] = ~way[0];
            end
        end
        return nb;
    endfunction

    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [2:0]         hit_status;
    logic               found_inv;
    logic [WAY_W-1:0]   inv_way;
    logic [2:0]         plru_rd;
    logic [1:0]         plru_way2;
    logic [WAY_W-1:0]   victim_way;
    logic [ENTRY_W-1:0] victim_entry;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        hit_status = '0;
        found_inv  = 1'b0;
        inv_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && rd_entry[w][TAG_LEN] && (rd_entry[w][TAG_LEN-1:0] == bus.tag_in)) begin
                hit        = 1'b1;
                hit_way    = WAY_W'(w);
                hit_status = rd_entry[w][ENTRY_W-1:TAG_LEN];
            end
            if (!found_inv && !rd_entry[w][TAG_LEN]) begin
                found_inv = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end

        plru_rd   = plru_q[bus.addr];
        plru_way2 = 2'b00;
        if (WAYS == 2) begin
            plru_way2 = {1'b0, plru_rd[0]};
        end else if (WAYS == 4) begin
            plru_way2 = plru_rd[0] ? {1'b1, plru_rd[2]} : {1'b0, plru_rd[1]};
        end
        victim_way = found_inv ? inv_way : WAY_W'(plru_way2);

        victim_entry = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == victim_way) begin
                victim_entry = rd_entry[w];
            end
        end
    end

    // Sweep clears PLRU alongside the tags; unused high bits stay zero for small WAYS.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            plru_q[sweep_q] <= '0;
        end else if (do_write) begin
            plru_q[bus.addr] <= plru_touch(plru_rd, 2'(bus.way_in));
        end else if (do_lookup && hit) begin
            plru_q[bus.addr] <= plru_touch(plru_rd, 2'(hit_way));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= StInit;
            sweep_q         <= '0;
            ready_q         <= 1'b0;
            rvalid_q        <= 1'b0;
            hit_q           <= 1'b0;
            hit_way_q       <= '0;
            hit_status_q    <= '0;
            victim_way_q    <= '0;
            victim_tag_q    <= '0;
            victim_status_q <= '0;
        end else begin
            rvalid_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == '1) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (do_lookup) begin
                        rvalid_q        <= 1'b1;
                        hit_q           <= hit;
                        hit_way_q       <= hit_way;
                        hit_status_q    <= hit_status;
                        victim_way_q    <= victim_way;
                        victim_tag_q    <= victim_entry[TAG_LEN-1:0];
                        victim_status_q <= victim_entry[ENTRY_W-1:TAG_LEN];
                    end
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    assign bus.ready         = ready_q;
    assign bus.rvalid        = rvalid_q;
    assign bus.hit           = hit_q;
    assign bus.hit_way       = hit_way_q;
    assign bus.hit_status    = hit_status_q;
    assign bus.victim_way    = victim_way_q;
    assign bus.victim_tag    = victim_tag_q;
    assign bus.victim_status = victim_status_q;
endmodule
